// File: rtl/hilo_mdu_pkg.sv
// +----------------------------------------------------------------------+
// | hilo_mdu_pkg : HILO command opcodes and MDU state encoding            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package hilo_mdu_pkg;

    localparam logic [3:0] HILO_MULT  = 4'd0;
    localparam logic [3:0] HILO_MULTU = 4'd1;
    localparam logic [3:0] HILO_DIV   = 4'd2;
    localparam logic [3:0] HILO_DIVU  = 4'd3;
    localparam logic [3:0] HILO_MFHI  = 4'd4;
    localparam logic [3:0] HILO_MTHI  = 4'd5;
    localparam logic [3:0] HILO_MFLO  = 4'd6;
    localparam logic [3:0] HILO_MTLO  = 4'd7;
    localparam logic [3:0] HILO_NONE  = 4'd8;

    typedef enum logic [0:0] {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/hilo_mdu.sv
// +----------------------------------------------------------------------+
// | hilo_mdu : multi-cycle multiply/divide unit owning the HI/LO pair     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  HILOOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HILOOut
);

    localparam int CNT_W = $clog2((DIV_CYCLES > MULT_CYCLES ? DIV_CYCLES : MULT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYCLES);

    mdu_state_t       state, state_next;
    logic [CNT_W-1:0] counter;
    logic [31:0]      hi, lo, p_hi, p_lo;
    logic             p_we;

    logic             is_mul, is_div, last_cycle;
    logic [31:0]      res_hi, res_lo;
    logic             res_we;
    logic [63:0]      prod_s, prod_u;

    assign is_mul     = (HILOOp == HILO_MULT) || (HILOOp == HILO_MULTU);
    assign is_div     = (HILOOp == HILO_DIV)  || (HILOOp == HILO_DIVU);
    assign start      = (is_mul || is_div) && (state == MDU_IDLE);
    assign busy       = (state == MDU_RUN);
    assign last_cycle = (state == MDU_RUN) && (counter == CNT_W'(1));

    assign HILOOut = (HILOOp == HILO_MFHI) ? hi :
                     (HILOOp == HILO_MFLO) ? lo : 32'd0;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // A zero divisor leaves res_we low so completion does not touch HI/LO.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_we = 1'b0;
        case (HILOOp)
            HILO_MULT:  begin {res_hi, res_lo} = prod_s; res_we = 1'b1; end
            HILO_MULTU: begin {res_hi, res_lo} = prod_u; res_we = 1'b1; end
            HILO_DIV: begin
                if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_we = 1'b1;
                end else if (B != 32'd0) begin
                    res_lo = $signed(A) / $signed(B);
                    res_hi = $signed(A) % $signed(B);
                    res_we = 1'b1;
                end
            end
            HILO_DIVU: begin
                if (B != 32'd0) begin
                    res_lo = A / B;
                    res_hi = A % B;
                    res_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            MDU_IDLE: if (start)      state_next = MDU_RUN;
            MDU_RUN:  if (last_cycle) state_next = MDU_IDLE;
            default:                  state_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= MDU_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            p_hi    <= 32'd0;
            p_lo    <= 32'd0;
            p_we    <= 1'b0;
        end else if (start) begin
            p_hi    <= res_hi;
            p_lo    <= res_lo;
            p_we    <= res_we;
            counter <= is_mul ? C_MULT_CNT : C_DIV_CNT;
        end else if (state == MDU_RUN) begin
            counter <= counter - CNT_W'(1);
            if (last_cycle) begin
                p_we <= 1'b0;
                if (p_we) begin
                    hi <= p_hi;
                    lo <= p_lo;
                end
            end
        end else begin
            if (HILOOp == HILO_MTHI) hi <= A;
            if (HILOOp == HILO_MTLO) lo <= A;
        end
    end

endmodule

`default_nettype wire
